// File: rtl/mem_router_if.sv
// mem_router_if: CPU data port plus slave-side bus of the memory router.
//
// Handshake: the master raises i_req with i_we/i_address/i_wdata; the router
// samples it only while idle (o_busy low) and later returns exactly one
// o_ack pulse, with o_err/o_rdata valid in that same cycle. On the slave
// side the router holds one bit of o_DV plus o_address/o_wdata/o_we stable
// until the selected slave pulses its bit of i_slave_ack. Acks from other
// slaves are ignored.
//
// Modports:
//   slave  - the router's view (consumes requests, drives responses/selects)
//   master - the environment's view (CPU and slaves together)
// o_state is a debug copy of the router FSM state (0 IDLE, 1 WAIT, 2 RESP, 3 ERR).
interface mem_router_if #(
  parameter int N_SLAVES = 7,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  logic                       i_req;
  logic                       i_we;
  logic [ADDR_W-1:0]          i_address;
  logic [DATA_W-1:0]          i_wdata;
  logic                       o_busy;
  logic                       o_ack;
  logic                       o_err;
  logic [DATA_W-1:0]          o_rdata;
  logic [N_SLAVES-1:0]        o_DV;
  logic [ADDR_W-1:0]          o_address;
  logic [DATA_W-1:0]          o_wdata;
  logic                       o_we;
  logic [N_SLAVES-1:0]        i_slave_ack;
  logic [N_SLAVES*DATA_W-1:0] i_slave_rdata;
  logic [1:0]                 o_state;

  modport slave (
    input  i_req, i_we, i_address, i_wdata, i_slave_ack, i_slave_rdata,
    output o_busy, o_ack, o_err, o_rdata, o_DV, o_address, o_wdata, o_we,
           o_state
  );

  modport master (
    output i_req, i_we, i_address, i_wdata, i_slave_ack, i_slave_rdata,
    input  o_busy, o_ack, o_err, o_rdata, o_DV, o_address, o_wdata, o_we,
           o_state
  );
endinterface

// File: rtl/mem_router.sv
// mem_router: registered address router from the CPU data port to N
// memory-mapped slaves, each owning a window [base, limit).
//
// Ports:
//   i_clk  - clock, all logic on the rising edge
//   i_rst  - synchronous active-high reset, aborts any transaction
//   bus    - mem_router_if.slave: CPU request/response and slave select bus
//
// A request latched in IDLE is decoded against every window (lowest index
// wins on overlap). A hit selects that slave until it acks (-> RESP) or the
// wait counter reaches TIMEOUT (-> ERR). A miss goes straight to ERR. RESP
// and ERR each last one cycle and produce the single o_ack pulse.
module mem_router #(
  parameter int N_SLAVES = 7,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = {
    32'h6000_0000, 32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
    32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] REGION_LIMIT = {
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h0000_2000},
  parameter int TIMEOUT = 255
) (
  input logic         i_clk,
  input logic         i_rst,
  mem_router_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_SLAVES-1:0] dv_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  logic [N_SLAVES-1:0] dec_dv;
  logic                dec_hit;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout_hit;

  // Window decode of the incoming address. Scanning from the top index down
  // lets the lowest matching index overwrite the others, so dec_dv is
  // always one-hot or zero.
  always_comb begin
    dec_dv  = '0;
    dec_hit = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.i_address >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
          (bus.i_address <  REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
        dec_dv  = N_SLAVES'(1) << i;
        dec_hit = 1'b1;
      end
    end
  end

  // Only the currently selected slave may complete the transaction.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dv_q[i]) begin
        sel_rdata = sel_rdata | bus.i_slave_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ack = |(bus.i_slave_ack & dv_q);

  // Saturating wait counter; cnt_d is the count including the current WAIT
  // cycle, so select stays high for exactly TIMEOUT cycles.
  assign cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d >= TIMEOUT_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      dv_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_req) begin
            addr_q  <= bus.i_address;
            wdata_q <= bus.i_wdata;
            we_q    <= bus.i_we;
            busy_q  <= 1'b1;
            if (dec_hit) begin
              dv_q    <= dec_dv;
              cnt_q   <= '0;
              state_q <= ST_WAIT;
            end else begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          // An ack on the timeout boundary still completes normally.
          if (sel_ack) begin
            rdata_q <= we_q ? '0 : sel_rdata;
            ack_q   <= 1'b1;
            dv_q    <= '0;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            dv_q    <= '0;
            state_q <= ST_ERR;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          dv_q    <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_err     = err_q;
  assign bus.o_rdata   = rdata_q;
  assign bus.o_DV      = dv_q;
  assign bus.o_address = addr_q;
  assign bus.o_wdata   = wdata_q;
  assign bus.o_we      = we_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_mem_router.sv
module tb_mem_router;
  localparam int NS = 7;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [NS-1:0]    s_ack;
  logic [NS*DW-1:0] s_rdata;

  int errors = 0;
  int checks = 0;
  int sel_dut = 0;  // 0 default map, 1 TIMEOUT=4, 2 overlapping windows

  logic [DW:0] exp_q[$];  // {err, rdata}
  logic [DW:0] exp_e;

  mem_router_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) if_a ();
  mem_router_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) if_t ();
  mem_router_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) if_o ();

  assign if_a.i_req = req;   assign if_t.i_req = req;   assign if_o.i_req = req;
  assign if_a.i_we = we;     assign if_t.i_we = we;     assign if_o.i_we = we;
  assign if_a.i_address = addr;  assign if_t.i_address = addr;  assign if_o.i_address = addr;
  assign if_a.i_wdata = wdata;   assign if_t.i_wdata = wdata;   assign if_o.i_wdata = wdata;
  assign if_a.i_slave_ack = s_ack;   assign if_t.i_slave_ack = s_ack;   assign if_o.i_slave_ack = s_ack;
  assign if_a.i_slave_rdata = s_rdata; assign if_t.i_slave_rdata = s_rdata; assign if_o.i_slave_rdata = s_rdata;

  mem_router #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a)
  );

  mem_router #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst(rst), .bus(if_t)
  );

  // Slaves 1 and 2 both cover [0x10000000, 0x30000000).
  mem_router #(
    .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .REGION_BASE({32'h6000_0000, 32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
                  32'h1000_0000, 32'h1000_0000, 32'h0000_0000}),
    .REGION_LIMIT({32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                   32'h3000_0000, 32'h3000_0000, 32'h0000_2000})
  ) dut_o (
    .i_clk(clk), .i_rst(rst), .bus(if_o)
  );

  // ---------------- observed outputs of the DUT under test ----------------
  logic          obs_busy, obs_ack, obs_err, obs_we;
  logic [DW-1:0] obs_rdata, obs_wdata;
  logic [AW-1:0] obs_addr;
  logic [NS-1:0] obs_dv;
  logic [1:0]    obs_state;

  always_comb begin
    obs_busy = if_a.o_busy;  obs_ack = if_a.o_ack;   obs_err = if_a.o_err;
    obs_we = if_a.o_we;      obs_rdata = if_a.o_rdata; obs_wdata = if_a.o_wdata;
    obs_addr = if_a.o_address; obs_dv = if_a.o_DV;   obs_state = if_a.o_state;
    if (sel_dut == 1) begin
      obs_busy = if_t.o_busy;  obs_ack = if_t.o_ack;   obs_err = if_t.o_err;
      obs_we = if_t.o_we;      obs_rdata = if_t.o_rdata; obs_wdata = if_t.o_wdata;
      obs_addr = if_t.o_address; obs_dv = if_t.o_DV;   obs_state = if_t.o_state;
    end else if (sel_dut == 2) begin
      obs_busy = if_o.o_busy;  obs_ack = if_o.o_ack;   obs_err = if_o.o_err;
      obs_we = if_o.o_we;      obs_rdata = if_o.o_rdata; obs_wdata = if_o.o_wdata;
      obs_addr = if_o.o_address; obs_dv = if_o.o_DV;   obs_state = if_o.o_state;
    end
  end

  // ---------------- scoreboard: every response pops one expectation ----------------
  always @(negedge clk) begin
    if (obs_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack err=%b rdata=%h, required no response",
                 obs_err, obs_rdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({obs_err, obs_rdata} !== exp_e) begin
          errors++;
          $display("FAIL response: got err=%b rdata=%h, required err=%b rdata=%h",
                   obs_err, obs_rdata, exp_e[DW], exp_e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req = 1'b0; s_ack = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request for one cycle; returns at the negedge after the
  // sampling edge (first cycle in which o_DV is visible).
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = $urandom; wdata = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel_dut = 0;
    do_reset(3);
    checks++;
    if ({obs_busy, obs_ack, obs_err, obs_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 0000", {obs_busy, obs_ack, obs_err, obs_we});
    end
    checks++;
    if (obs_dv !== '0) begin errors++; $display("FAIL reset_dv: got %b, required 0", obs_dv); end
    checks++;
    if (obs_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", obs_rdata); end
    checks++;
    if (obs_addr !== '0 || obs_wdata !== '0) begin
      errors++; $display("FAIL reset_addr_wdata: got %h/%h, required 0/0", obs_addr, obs_wdata);
    end
    checks++;
    if (obs_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", obs_state); end
  endtask

  task automatic test_read_basic();
    sel_dut = 0;
    s_rdata = '0;
    s_rdata[DW-1:0] = 32'hDEAD_BEEF;
    issue(32'h0000_0100, 1'b0, '0);
    checks++;
    if (obs_dv !== 7'b0000001) begin errors++; $display("FAIL read_dv: got %b, required 0000001", obs_dv); end
    checks++;
    if (obs_busy !== 1'b1 || obs_ack !== 1'b0) begin
      errors++; $display("FAIL read_busy: got busy=%b ack=%b, required 1/0", obs_busy, obs_ack);
    end
    s_ack = 7'b0000001;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    s_ack = '0;
    checks++;
    if (obs_ack !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'hDEAD_BEEF || obs_dv !== '0) begin
      errors++; $display("FAIL read_ack_t2: got ack=%b err=%b rdata=%h dv=%b, required 1/0/deadbeef/0",
                         obs_ack, obs_err, obs_rdata, obs_dv);
    end
    @(negedge clk);
    checks++;
    if (obs_busy !== 1'b0 || obs_ack !== 1'b0) begin
      errors++; $display("FAIL read_idle: got busy=%b ack=%b, required 0/0", obs_busy, obs_ack);
    end
  endtask

  task automatic test_boundaries();
    logic [AW-1:0] ba [9];
    logic [NS-1:0] bd [9];
    logic [NS-1:0] cur_dv;
    logic [DW-1:0] rd, exp_r;
    int lat;
    sel_dut = 0;
    ba = '{32'h0000_0000, 32'h0000_1FFF, 32'h0000_2000, 32'h1FFF_FFFF, 32'h2000_0000,
           32'h5FFF_FFFF, 32'h6FFF_FFFF, 32'h7000_0000, 32'hFFFF_FFFF};
    bd = '{7'b0000001, 7'b0000001, 7'b0000000, 7'b0000010, 7'b0000100,
           7'b0100000, 7'b1000000, 7'b0000000, 7'b0000000};
    for (int k = 0; k < 9; k++) begin
      cur_dv = bd[k];
      if (cur_dv == '0) begin
        exp_q.push_back({1'b1, {DW{1'b0}}});
        issue(ba[k], 1'b0, '0);
        checks++;
        if (obs_ack !== 1'b1 || obs_err !== 1'b1 || obs_dv !== '0) begin
          errors++; $display("FAIL unmapped_%h: got ack=%b err=%b dv=%b, required 1/1/0",
                             ba[k], obs_ack, obs_err, obs_dv);
        end
        @(negedge clk);
        checks++;
        if (obs_dv !== '0 || obs_busy !== 1'b0) begin
          errors++; $display("FAIL unmapped_after_%h: got dv=%b busy=%b, required 0/0", ba[k], obs_dv, obs_busy);
        end
      end else begin
        issue(ba[k], 1'b0, '0);
        checks++;
        if (obs_dv !== cur_dv) begin
          errors++; $display("FAIL decode_%h: got dv=%b, required %b", ba[k], obs_dv, cur_dv);
        end
        lat = $urandom_range(0, 3);
        repeat (lat) @(negedge clk);
        rd = $urandom;
        exp_r = '0;
        for (int j = 0; j < NS; j++) begin
          s_rdata[j*DW +: DW] = rd ^ DW'(j);
          if (cur_dv[j]) exp_r = rd ^ DW'(j);
        end
        s_ack = cur_dv;
        exp_q.push_back({1'b0, exp_r});
        @(negedge clk);
        s_ack = '0;
        checks++;
        if (obs_ack !== 1'b1) begin
          errors++; $display("FAIL hit_ack_%h: got ack=%b, required 1", ba[k], obs_ack);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_write_stray();
    sel_dut = 0;
    issue(32'h4000_0004, 1'b1, 32'h1234_5678);
    checks++;
    if (obs_dv !== 7'b0010000 || obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678 ||
        obs_addr !== 32'h4000_0004) begin
      errors++; $display("FAIL write_latch: got dv=%b we=%b wdata=%h addr=%h, required 0010000/1/12345678/40000004",
                         obs_dv, obs_we, obs_wdata, obs_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      s_ack = (c == 2 || c == 3) ? 7'b0000100 : 7'b0000000;
      s_rdata[2*DW +: DW] = $urandom;
      @(negedge clk);
      s_ack = '0;
      checks++;
      if (obs_dv !== 7'b0010000 || obs_ack !== 1'b0 || obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678) begin
        errors++; $display("FAIL write_hold_%0d: got dv=%b ack=%b we=%b wdata=%h, required 0010000/0/1/12345678",
                           c, obs_dv, obs_ack, obs_we, obs_wdata);
      end
    end
    s_rdata[4*DW +: DW] = 32'hCAFE_F00D;
    s_ack = 7'b0010000;
    exp_q.push_back({1'b0, {DW{1'b0}}});
    @(negedge clk);
    s_ack = '0;
    checks++;
    if (obs_ack !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== '0) begin
      errors++; $display("FAIL write_ack: got ack=%b err=%b rdata=%h, required 1/0/0", obs_ack, obs_err, obs_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int acks;
    sel_dut = 0;
    issue(32'h3000_0010, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    s_ack = 7'b0001000;
    s_rdata[3*DW +: DW] = 32'hA5A5_5A5A;
    @(negedge clk);
    rst = 1'b0;
    s_ack = '0;
    checks++;
    if ({obs_busy, obs_ack, obs_err, obs_we} !== 4'b0 || obs_dv !== '0 || obs_rdata !== '0 ||
        obs_addr !== '0 || obs_wdata !== '0 || obs_state !== 2'd0) begin
      errors++; $display("FAIL reset_mid_wait: got busy=%b ack=%b dv=%b rdata=%h addr=%h state=%0d, required all 0",
                         obs_busy, obs_ack, obs_dv, obs_rdata, obs_addr, obs_state);
    end
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (obs_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_no_ack: got %0d acks, required 0", acks); end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    logic [DW-1:0] rd;
    do_reset(2);
    sel_dut = 1;
    exp_q.push_back({1'b1, {DW{1'b0}}});
    issue(32'h2000_0000, 1'b0, '0);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (obs_ack === 1'b1) begin seen = 1'b1; break; end
      if (obs_dv === 7'b0000100) n++;
      @(negedge clk);
    end
    checks++;
    if (!seen || n != 4) begin
      errors++; $display("FAIL timeout_dv_cycles: got ack_seen=%b dv_cycles=%0d, required 1/4", seen, n);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_dv !== '0) begin
      errors++; $display("FAIL timeout_err: got err=%b dv=%b, required 1/0", obs_err, obs_dv);
    end
    @(negedge clk);
    issue(32'h2000_0000, 1'b0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_dv !== 7'b0000100 || obs_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_4th_cycle: got dv=%b ack=%b, required 0000100/0", obs_dv, obs_ack);
    end
    rd = $urandom;
    s_rdata[2*DW +: DW] = rd;
    s_ack = 7'b0000100;
    exp_q.push_back({1'b0, rd});
    @(negedge clk);
    s_ack = '0;
    checks++;
    if (obs_ack !== 1'b1 || obs_err !== 1'b0) begin
      errors++; $display("FAIL timeout_boundary_ack: got ack=%b err=%b, required 1/0", obs_ack, obs_err);
    end
    @(negedge clk);
  endtask

  task automatic test_overlap_back_to_back();
    logic [NS-1:0] prev_dv;
    logic [DW-1:0] rd;
    int n_txn, n_ack;
    do_reset(2);
    sel_dut = 2;
    prev_dv = '0; n_txn = 0; n_ack = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h2000_0000; wdata = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 30) req = 1'b0;
      s_ack = '0;
      if (obs_ack === 1'b1) n_ack++;
      if (obs_dv !== '0 && prev_dv === '0) begin
        n_txn++;
        checks++;
        if (obs_dv !== 7'b0000010) begin
          errors++; $display("FAIL overlap_dv: got %b, required 0000010", obs_dv);
        end
        rd = $urandom;
        s_rdata[DW +: DW]   = rd;
        s_rdata[2*DW +: DW] = ~rd;
        s_ack = obs_dv;
        exp_q.push_back({1'b0, rd});
      end
      prev_dv = obs_dv;
    end
    checks++;
    if (n_txn != n_ack || n_txn < 5) begin
      errors++; $display("FAIL one_txn_per_ack: got txns=%0d acks=%0d, required equal and >=5", n_txn, n_ack);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    s_ack = '0; s_rdata = '0;
    test_reset();
    test_read_basic();
    test_boundaries();
    test_write_stray();
    test_reset_mid_wait();
    test_timeout();
    test_overlap_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
